// File: rtl/ddr_line_client.sv
// ddr_line_client
//
// Single-line write-back cache between a 32-bit CPU port and a 128-bit DDR
// wrapper. One 128-bit line is kept together with its tag (address bits
// [31:4]), a valid bit and a dirty bit. Hits complete with a one-cycle ack.
// A miss first writes back a dirty line (WB) and then fetches the requested
// line (FILL). After the line is loaded, the pending read or write is applied.
// Every DDR transaction is bounded by TIMEOUT cycles. On expiry, err is set
// (sticky), the line is invalidated, and the CPU gets one ack carrying
// 32'hDEADBEEF. The block then waits for the wrapper to report ready again.
//
// Ports
//   clk100mhz        clock, all state changes on the rising edge
//   rst              asynchronous active-high reset
//   cpu_req/cpu_we   request strobe and write(1)/read(0) select
//   cpu_addr         byte address; [3:2] selects the word, [1:0] ignored
//   cpu_wdata        write word
//   cpu_rdata        read word, valid with cpu_ack and held until next ack
//   cpu_ack          one-cycle completion pulse
//   cpu_ready        high while requests are accepted (IDLE)
//   err              sticky DDR timeout flag
//   ddr_addr/ddr_wdata/ddr_rw   registered DDR request (rw: 1 write, 0 read)
//   ddr_rdata        line returned by the wrapper
//   ddr_busy         wrapper busy (informational only)
//   ddr_done         transaction completion from the wrapper
//   ddr_start_ready  wrapper initialised and able to take requests
module ddr_line_client #(
    parameter int TIMEOUT = 4096
) (
    input  logic         clk100mhz,
    input  logic         rst,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ack,
    output logic         cpu_ready,
    output logic         err,
    output logic [31:0]  ddr_addr,
    output logic [127:0] ddr_wdata,
    output logic         ddr_rw,
    input  logic [127:0] ddr_rdata,
    input  logic         ddr_busy,
    input  logic         ddr_done,
    input  logic         ddr_start_ready
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WB,
        FILL,
        RESP,
        ERR
    } state_t;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0]   ERR_WORD = 32'hDEADBEEF;

    state_t         state_reg, state_next;
    logic [127:0]   line_reg, line_next;
    logic [27:0]    tag_reg, tag_next;
    logic           valid_reg, valid_next;
    logic           dirty_reg, dirty_next;
    logic           req_we_reg, req_we_next;
    logic [29:0]    req_addr_reg, req_addr_next;   // latched cpu_addr[31:2]
    logic [31:0]    req_wdata_reg, req_wdata_next;
    logic [31:0]    rdata_reg, rdata_next;
    logic           err_reg, err_next;
    logic [31:0]    ddr_addr_reg, ddr_addr_next;
    logic [127:0]   ddr_wdata_reg, ddr_wdata_next;
    logic           ddr_rw_reg, ddr_rw_next;
    logic [CW-1:0]  cnt_reg, cnt_next;

    // ddr_busy never steers the FSM; the wrapper's done pulse is authoritative.
    logic unused_inputs;
    assign unused_inputs = ^{ddr_busy, cpu_addr[1:0]};

    // Word views of the held line and of the line coming back from DDR.
    logic [31:0] line_word [4];
    logic [31:0] fill_word [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_word
        assign line_word[gi] = line_reg[gi*32 +: 32];
        assign fill_word[gi] = ddr_rdata[gi*32 +: 32];
    end

    logic [1:0] req_sel;
    logic       cpu_hit;
    logic       done_ok;
    logic       timed_out;

    assign req_sel   = req_addr_reg[1:0];
    assign cpu_hit   = valid_reg && (tag_reg == cpu_addr[31:4]);
    // A done seen in the first cycle of WB/FILL may belong to an earlier
    // transaction, so it only counts once the counter has moved.
    assign done_ok   = ddr_done && (cnt_reg != '0);
    assign timed_out = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            state_reg     <= INIT;
            line_reg      <= '0;
            tag_reg       <= '0;
            valid_reg     <= 1'b0;
            dirty_reg     <= 1'b0;
            req_we_reg    <= 1'b0;
            req_addr_reg  <= '0;
            req_wdata_reg <= '0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            ddr_addr_reg  <= '0;
            ddr_wdata_reg <= '0;
            ddr_rw_reg    <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            line_reg      <= line_next;
            tag_reg       <= tag_next;
            valid_reg     <= valid_next;
            dirty_reg     <= dirty_next;
            req_we_reg    <= req_we_next;
            req_addr_reg  <= req_addr_next;
            req_wdata_reg <= req_wdata_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
            ddr_addr_reg  <= ddr_addr_next;
            ddr_wdata_reg <= ddr_wdata_next;
            ddr_rw_reg    <= ddr_rw_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        line_next      = line_reg;
        tag_next       = tag_reg;
        valid_next     = valid_reg;
        dirty_next     = dirty_reg;
        req_we_next    = req_we_reg;
        req_addr_next  = req_addr_reg;
        req_wdata_next = req_wdata_reg;
        rdata_next     = rdata_reg;
        err_next       = err_reg;
        ddr_addr_next  = ddr_addr_reg;
        ddr_wdata_next = ddr_wdata_reg;
        ddr_rw_next    = ddr_rw_reg;
        cnt_next       = cnt_reg;

        case (state_reg)
            INIT: begin
                if (ddr_start_ready) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                if (cpu_req) begin
                    req_we_next    = cpu_we;
                    req_addr_next  = cpu_addr[31:2];
                    req_wdata_next = cpu_wdata;
                    if (cpu_hit) begin
                        if (cpu_we) begin
                            line_next[{cpu_addr[3:2], 5'b0} +: 32] = cpu_wdata;
                            dirty_next = 1'b1;
                            rdata_next = cpu_wdata;
                        end else begin
                            rdata_next = line_word[cpu_addr[3:2]];
                        end
                        state_next = RESP;
                    end else if (valid_reg && dirty_reg) begin
                        // Evict the current line before fetching the new one.
                        ddr_addr_next  = {tag_reg, 4'b0};
                        ddr_wdata_next = line_reg;
                        ddr_rw_next    = 1'b1;
                        cnt_next       = '0;
                        state_next     = WB;
                    end else begin
                        ddr_addr_next = {cpu_addr[31:4], 4'b0};
                        ddr_rw_next   = 1'b0;
                        cnt_next      = '0;
                        state_next    = FILL;
                    end
                end
            end

            WB: begin
                if (done_ok) begin
                    dirty_next    = 1'b0;
                    ddr_addr_next = {req_addr_reg[29:2], 4'b0};
                    ddr_rw_next   = 1'b0;
                    cnt_next      = '0;
                    state_next    = FILL;
                end else if (timed_out) begin
                    err_next    = 1'b1;
                    valid_next  = 1'b0;
                    ddr_rw_next = 1'b0;
                    rdata_next  = ERR_WORD;
                    state_next  = ERR;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            FILL: begin
                if (done_ok) begin
                    line_next  = ddr_rdata;
                    tag_next   = req_addr_reg[29:2];
                    valid_next = 1'b1;
                    dirty_next = 1'b0;
                    if (req_we_reg) begin
                        line_next[{req_sel, 5'b0} +: 32] = req_wdata_reg;
                        dirty_next = 1'b1;
                        rdata_next = req_wdata_reg;
                    end else begin
                        rdata_next = fill_word[req_sel];
                    end
                    ddr_rw_next = 1'b0;
                    state_next  = RESP;
                end else if (timed_out) begin
                    err_next    = 1'b1;
                    valid_next  = 1'b0;
                    ddr_rw_next = 1'b0;
                    rdata_next  = ERR_WORD;
                    state_next  = ERR;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            ERR: begin
                // The wrapper is suspect after a timeout; wait for it again.
                state_next = INIT;
            end

            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign cpu_ready = (state_reg == IDLE);
    assign cpu_ack   = (state_reg == RESP) || (state_reg == ERR);
    assign cpu_rdata = rdata_reg;
    assign err       = err_reg;
    assign ddr_addr  = ddr_addr_reg;
    assign ddr_wdata = ddr_wdata_reg;
    assign ddr_rw    = ddr_rw_reg;

endmodule
